// File: rtl/pipe_buf_pkg.sv
// rtl/pipe_buf_pkg.sv - sizing helpers and occupancy state shared by pipe_elastic_buffer
package pipe_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } buf_state_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// rtl/pipe_buf_mem.sv - DEPTH x DWIDTH register array, sync write, async read, sync reset
module pipe_buf_mem #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_elastic_buffer.sv
// rtl/pipe_elastic_buffer.sv - multi-entry valid/ready elastic buffer; PIPE_BUF_FLUSH_EN adds i_flush
module pipe_elastic_buffer
  import pipe_buf_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int DEPTH       = 4,
  parameter int FALLTHROUGH = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DWIDTH-1:0]         i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [DWIDTH-1:0]         o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [cnt_w(DEPTH)-1:0]   o_count
`ifdef PIPE_BUF_FLUSH_EN
  ,
  input  logic                      i_flush
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("pipe_elastic_buffer: DEPTH must be a power of two >= 2");
  end

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic              flush, empty, bypass, byp_xfer, push, pop, wr_en, rd_adv;
  logic [DWIDTH-1:0] mem_rdata;
  buf_state_e        state;

`ifdef PIPE_BUF_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Bypass is gated by ready_q so nothing is presented before the buffer can accept it.
  assign empty    = (count_q == '0);
  assign bypass   = (FALLTHROUGH != 0) && empty && ready_q;
  assign o_valid  = !empty || (bypass && i_valid);
  assign o_data   = bypass ? i_data : mem_rdata;
  assign o_ready  = ready_q;
  assign o_count  = count_q;

  assign push     = i_valid && ready_q;
  assign pop      = o_valid && i_ready;
  assign byp_xfer = bypass && pop;
  assign wr_en    = push && !byp_xfer && !flush;
  assign rd_adv   = pop && !byp_xfer && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !rd_adv)      count_d = count_q + CNT_W'(1);
      else if (rd_adv && !wr_en) count_d = count_q - CNT_W'(1);
    end
    ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  pipe_buf_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    if (empty)                    state = EMPTY;
    else if (count_q == FULL_CNT) state = FULL;
    else                          state = PARTIAL;
  end

  always_ff @(posedge clk) begin
    if (reset_n) assert (!(state == FULL && ready_q));
  end

endmodule

// File: tb/tb_pipe_elastic_buffer.sv
// tb/tb_pipe_elastic_buffer.sv - randomized self-checking bench for pipe_elastic_buffer
module tb_pipe_elastic_buffer;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0][7:0] idata;
  logic [2:0][7:0] odata;
  logic [2:0] ivalid, iready, oready, ovalid;
`ifdef PIPE_BUF_FLUSH_EN
  logic [2:0] iflush;
`endif
  logic [2:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic [2:0][3:0] ocount;
  logic [2:0] rdy;
  int n_checks = 0;
  int n_fail = 0;
  int dep [3] = '{4, 4, 8};
  int ft  [3] = '{0, 1, 0};
  logic [7:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  assign ocount[0] = {1'b0, cnt_a};
  assign ocount[1] = {1'b0, cnt_b};
  assign ocount[2] = cnt_c;

  pipe_elastic_buffer #(.DWIDTH(8), .DEPTH(4), .FALLTHROUGH(0)) dut_d4 (
    .clk(clk), .reset_n(rst_n), .i_data(idata[0]), .i_valid(ivalid[0]), .o_ready(oready[0]),
    .o_data(odata[0]), .o_valid(ovalid[0]), .i_ready(iready[0]), .o_count(cnt_a)
`ifdef PIPE_BUF_FLUSH_EN
    , .i_flush(iflush[0])
`endif
  );

  pipe_elastic_buffer #(.DWIDTH(8), .DEPTH(4), .FALLTHROUGH(1)) dut_f4 (
    .clk(clk), .reset_n(rst_n), .i_data(idata[1]), .i_valid(ivalid[1]), .o_ready(oready[1]),
    .o_data(odata[1]), .o_valid(ovalid[1]), .i_ready(iready[1]), .o_count(cnt_b)
`ifdef PIPE_BUF_FLUSH_EN
    , .i_flush(iflush[1])
`endif
  );

  pipe_elastic_buffer #(.DWIDTH(8), .DEPTH(8), .FALLTHROUGH(0)) dut_d8 (
    .clk(clk), .reset_n(rst_n), .i_data(idata[2]), .i_valid(ivalid[2]), .o_ready(oready[2]),
    .o_data(odata[2]), .o_valid(ovalid[2]), .i_ready(iready[2]), .o_count(cnt_c)
`ifdef PIPE_BUF_FLUSH_EN
    , .i_flush(iflush[2])
`endif
  );

  // Reference model: one FIFO queue per instance plus the registered ready flag.
  function automatic int msize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] mhead(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic mpush(input int k, input logic [7:0] d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic mpop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic mclear(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic logic exp_valid(input int k);
    return (msize(k) != 0) || (ft[k] != 0 && ivalid[k] && rdy[k]);
  endfunction

  function automatic logic [7:0] exp_data(input int k);
    return (msize(k) != 0) ? mhead(k) : idata[k];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic push, pop;
      push = ivalid[k] && rdy[k];
      pop  = exp_valid(k) && iready[k];
      if (!rst_n) begin
        mclear(k);
        rdy[k] = 1'b0;
      end
`ifdef PIPE_BUF_FLUSH_EN
      else if (iflush[k]) begin
        mclear(k);
        rdy[k] = 1'b1;
      end
`endif
      else begin
        if (push) mpush(k, idata[k]);
        if (pop)  mpop(k);
        rdy[k] = (msize(k) != dep[k]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ivalid = 3'b111; iready = 3'b111;
    for (int k = 0; k < 3; k++) idata[k] = 8'($urandom);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (oready[k] !== 1'b0 || ovalid[k] !== 1'b0 || ocount[k] !== 4'd0 || odata[k] !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_hold dut%0d c%0d: ready=%b valid=%b count=%0d data=%h, want 0 0 0 00",
                   k, c, oready[k], ovalid[k], ocount[k], odata[k]);
        end
      end
      tick();
    end
    rst_n = 1'b1; ivalid = '0; iready = '0;
    tick(); #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (oready[k] !== 1'b1 || ovalid[k] !== 1'b0 || ocount[k] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_release dut%0d: ready=%b valid=%b count=%0d, want 1 0 0",
                 k, oready[k], ovalid[k], ocount[k]);
      end
    end
  endtask

  task automatic test_fill_drain();
    iready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idata[0] = 8'hA1 + 8'(i); ivalid[0] = 1'b1; #1;
      n_checks++;
      if (oready[0] !== 1'b1) begin
        n_fail++; $display("FAIL fill_ready i%0d: ready=%b want 1", i, oready[0]);
      end
      tick(); #1;
      n_checks++;
      if (ocount[0] !== 4'(i + 1)) begin
        n_fail++; $display("FAIL fill_count i%0d: count=%0d want %0d", i, ocount[0], i + 1);
      end
    end
    ivalid[0] = 1'b0; #1;
    n_checks++;
    if (oready[0] !== 1'b0 || ocount[0] !== 4'd4) begin
      n_fail++; $display("FAIL full_state: ready=%b count=%0d want 0 4", oready[0], ocount[0]);
    end
    iready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ovalid[0] !== 1'b1 || odata[0] !== 8'hA1 + 8'(i)) begin
        n_fail++; $display("FAIL drain_order i%0d: valid=%b data=%h want 1 %h", i, ovalid[0], odata[0], 8'hA1 + 8'(i));
      end
      tick();
      if (i == 0) begin
        #1; n_checks++;
        if (oready[0] !== 1'b1) begin
          n_fail++; $display("FAIL full_pop_ready: ready=%b want 1", oready[0]);
        end
      end
    end
    #1;
    n_checks++;
    if (ovalid[0] !== 1'b0 || ocount[0] !== 4'd0) begin
      n_fail++; $display("FAIL drained: valid=%b count=%0d want 0 0", ovalid[0], ocount[0]);
    end
    iready[0] = 1'b0;
  endtask

  task automatic test_streaming(input int k);
    int pops = 0;
    ivalid[k] = 1'b1; iready[k] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      logic       ev;
      logic [7:0] ed;
      logic [3:0] ec;
      idata[k] = 8'(c); #1;
      if (ft[k] != 0) begin ev = 1'b1; ed = 8'(c); ec = 4'd0; end
      else begin ev = (c > 0); ed = 8'(c - 1); ec = (c > 0) ? 4'd1 : 4'd0; end
      n_checks++;
      if (ovalid[k] !== ev || (ev && odata[k] !== ed) || ocount[k] !== ec) begin
        n_fail++;
        $display("FAIL stream dut%0d c%0d: valid=%b data=%h count=%0d want %b %h %0d",
                 k, c, ovalid[k], odata[k], ocount[k], ev, ed, ec);
      end
      if (ovalid[k] && iready[k]) pops++;
      tick();
    end
    ivalid[k] = 1'b0; #1;
    if (ovalid[k] && iready[k]) begin
      n_checks++;
      if (odata[k] !== 8'd19) begin
        n_fail++; $display("FAIL stream_tail dut%0d: data=%h want 13", k, odata[k]);
      end
      pops++;
    end
    tick(); #1;
    n_checks++;
    if (pops != 20 || ocount[k] !== 4'd0) begin
      n_fail++; $display("FAIL stream_total dut%0d: transfers=%0d count=%0d want 20 0", k, pops, ocount[k]);
    end
    iready[k] = 1'b0;
  endtask

  task automatic test_fallthrough();
    idata[1] = 8'h5C; ivalid[1] = 1'b1; iready[1] = 1'b1; #1;
    n_checks++;
    if (ovalid[1] !== 1'b1 || odata[1] !== 8'h5C || ocount[1] !== 4'd0) begin
      n_fail++; $display("FAIL ft_bypass: valid=%b data=%h count=%0d want 1 5c 0", ovalid[1], odata[1], ocount[1]);
    end
    tick(); #1;
    n_checks++;
    if (ocount[1] !== 4'd0) begin
      n_fail++; $display("FAIL ft_no_store: count=%0d want 0", ocount[1]);
    end
    iready[1] = 1'b0; #1;
    n_checks++;
    if (ovalid[1] !== 1'b1 || odata[1] !== 8'h5C) begin
      n_fail++; $display("FAIL ft_stall_present: valid=%b data=%h want 1 5c", ovalid[1], odata[1]);
    end
    tick();
    ivalid[1] = 1'b0; idata[1] = 8'h33; #1;
    n_checks++;
    if (ocount[1] !== 4'd1 || ovalid[1] !== 1'b1 || odata[1] !== 8'h5C) begin
      n_fail++; $display("FAIL ft_stall_hold: count=%0d valid=%b data=%h want 1 1 5c", ocount[1], ovalid[1], odata[1]);
    end
    iready[1] = 1'b1; tick(); iready[1] = 1'b0; #1;
    n_checks++;
    if (ocount[1] !== 4'd0) begin
      n_fail++; $display("FAIL ft_drain: count=%0d want 0", ocount[1]);
    end
  endtask

  task automatic test_wrap_stall(input int k, input int cycles);
    logic       stalled = 1'b0;
    logic [7:0] held = '0;
    for (int c = 0; c < cycles; c++) begin
      ivalid[k] = 1'($urandom_range(0, 1));
      iready[k] = 1'($urandom_range(0, 1));
      idata[k]  = 8'($urandom);
      #1;
      n_checks++;
      if (ovalid[k] !== exp_valid(k) || (exp_valid(k) && odata[k] !== exp_data(k))) begin
        n_fail++;
        $display("FAIL rand_out dut%0d c%0d: valid=%b data=%h want %b %h", k, c, ovalid[k], odata[k], exp_valid(k), exp_data(k));
      end
      n_checks++;
      if (oready[k] !== rdy[k] || ocount[k] !== 4'(msize(k)) || int'(ocount[k]) > dep[k]) begin
        n_fail++;
        $display("FAIL rand_state dut%0d c%0d: ready=%b count=%0d want %b %0d", k, c, oready[k], ocount[k], rdy[k], msize(k));
      end
      if (stalled) begin
        n_checks++;
        if (ovalid[k] !== 1'b1 || odata[k] !== held) begin
          n_fail++; $display("FAIL rand_stable dut%0d c%0d: valid=%b data=%h want 1 %h", k, c, ovalid[k], odata[k], held);
        end
      end
      stalled = ovalid[k] && !iready[k];
      held    = odata[k];
      tick();
    end
    ivalid[k] = 1'b0; iready[k] = 1'b1;
    repeat (dep[k] + 1) tick();
    iready[k] = 1'b0;
  endtask

`ifdef PIPE_BUF_FLUSH_EN
  task automatic test_flush();
    iready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idata[0] = 8'h10 + 8'(i); ivalid[0] = 1'b1; tick();
    end
    idata[0] = 8'hEE; iflush[0] = 1'b1; #1;
    n_checks++;
    if (ocount[0] !== 4'd3) begin
      n_fail++; $display("FAIL flush_pre: count=%0d want 3", ocount[0]);
    end
    tick();
    iflush[0] = 1'b0; ivalid[0] = 1'b0; #1;
    n_checks++;
    if (ocount[0] !== 4'd0 || ovalid[0] !== 1'b0 || oready[0] !== 1'b1) begin
      n_fail++; $display("FAIL flush_post: count=%0d valid=%b ready=%b want 0 0 1", ocount[0], ovalid[0], oready[0]);
    end
    iready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++;
      if (ovalid[0] !== 1'b0) begin
        n_fail++; $display("FAIL flush_dropped i%0d: valid=%b data=%h want 0", i, ovalid[0], odata[0]);
      end
    end
    iready[0] = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; idata = '0; ivalid = '0; iready = '0; rdy = '0;
`ifdef PIPE_BUF_FLUSH_EN
    iflush = '0;
`endif
    test_reset();
    test_fill_drain();
    test_streaming(0);
    test_streaming(1);
    test_fallthrough();
    test_wrap_stall(2, 1000);
    test_wrap_stall(1, 600);
`ifdef PIPE_BUF_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
